// File: rtl/irqc_pkg.sv
// Shared definitions for the interrupt controller: register offsets, error FSM states
// and the lowest-index-wins ID encoder.
package irqc_pkg;

    localparam logic [2:0] OFS_RAW     = 3'd0;
    localparam logic [2:0] OFS_ENABLE  = 3'd1;
    localparam logic [2:0] OFS_PENDING = 3'd2;
    localparam logic [2:0] OFS_MODE    = 3'd3;
    localparam logic [2:0] OFS_ID      = 3'd4;
    localparam logic [2:0] OFS_SWSET   = 3'd5;

    localparam logic [4:0] ID_NONE = 5'h1F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } err_state_t;

    function automatic logic is_mapped(input logic [2:0] ofs);
        return (ofs <= OFS_SWSET);
    endfunction

    // Returns {valid, idx}; scanning downwards lets the lowest set index win.
    function automatic logic [5:0] id_encode(input logic [30:0] vec);
        logic [5:0] res;
        res = {1'b0, ID_NONE};
        for (int i = 30; i >= 0; i--) begin
            if (vec[i]) res = {1'b1, 5'(i)};
        end
        return res;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// AHB-lite slave port bundle for the interrupt controller.
interface irq_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] haddr;
    logic [31:0]       hwdata;
    logic [31:0]       hrdata;
    logic              hwrite;
    logic [1:0]        htrans;
    logic              hsel;
    logic              hready;
    logic              hready_out;
    logic              hresp;

    modport slave (
        input  haddr, hwdata, hwrite, htrans, hsel, hready,
        output hrdata, hready_out, hresp
    );

    modport master (
        output haddr, hwdata, hwrite, htrans, hsel, hready,
        input  hrdata, hready_out, hresp
    );
endinterface

// File: rtl/irqc_src_cell.sv
// One interrupt source: optional 2-flop synchronizer (IRQC_SYNC_EN), edge detect and pending flop.
module irqc_src_cell (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic mode,
    input  logic w1c,
    input  logic swset,
    output logic raw,
    output logic pending
);

`ifdef IRQC_SYNC_EN
    logic sync1;
    logic sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= src;
            sync2 <= sync1;
        end
    end

    assign raw = sync2;
`else
    assign raw = src;
`endif

    logic prev;

    // Edge mode: set terms win over a same-cycle W1C. Level mode tracks raw.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev    <= 1'b0;
            pending <= 1'b0;
        end else begin
            prev <= raw;
            if (mode) pending <= (raw & ~prev) | swset | (pending & ~w1c);
            else      pending <= raw;
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// AHB-lite interrupt controller: latches edge/level sources, masks with ENABLE, drives irq.
// Build option IRQC_SYNC_EN adds a 2-flop synchronizer in front of every source.
module irq_ctrl
    import irqc_pkg::*;
#(
    parameter int NUM_SRC = 7,
    parameter int ADDR_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    irq_ctrl_if.slave          bus,
    output logic [NUM_SRC-1:0] irq
);

    logic [ADDR_W-1:0]  haddr_w;
    logic [2:0]         ofs;
    logic               acc;
    logic               acc_bad;

    logic               dp_valid;
    logic               dp_write;
    logic [2:0]         dp_ofs;
    logic               wr;
    logic               rd;

    logic [NUM_SRC-1:0] wdata;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] mode;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] swset;
    logic [NUM_SRC-1:0] raw;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] pend_en;
    logic [5:0]         id;

    err_state_t state;
    err_state_t state_nxt;

    logic unused_bits;

    assign haddr_w = bus.haddr;
    assign ofs     = haddr_w[4:2];
    assign acc     = bus.hsel & bus.htrans[1] & bus.hready;
    assign acc_bad = acc & ~is_mapped(ofs);
    assign wdata   = bus.hwdata[NUM_SRC-1:0];

    assign unused_bits = ^{haddr_w[ADDR_W-1:5], haddr_w[1:0], bus.hwdata[31:NUM_SRC], bus.htrans[0]};

    // Only mapped accesses reach the data phase, so unmapped ones never touch registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_ofs   <= 3'd0;
        end else begin
            dp_valid <= acc & is_mapped(ofs);
            dp_write <= bus.hwrite;
            dp_ofs   <= ofs;
        end
    end

    assign wr = dp_valid & dp_write;
    assign rd = dp_valid & ~dp_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable <= '0;
            mode   <= '0;
        end else if (wr) begin
            if (dp_ofs == OFS_ENABLE) enable <= wdata;
            if (dp_ofs == OFS_MODE)   mode   <= wdata;
        end
    end

    assign w1c   = (wr && dp_ofs == OFS_PENDING) ? wdata : '0;
    assign swset = (wr && dp_ofs == OFS_SWSET)   ? wdata : '0;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        irqc_src_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .src     (irq_src[i]),
            .mode    (mode[i]),
            .w1c     (w1c[i]),
            .swset   (swset[i]),
            .raw     (raw[i]),
            .pending (pending[i])
        );
    end

    assign pend_en = pending & enable;
    assign id      = id_encode(31'(pend_en));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq <= '0;
        else     irq <= pend_en;
    end

    always_comb begin
        bus.hrdata = 32'd0;
        if (rd) begin
            case (dp_ofs)
                OFS_RAW:     bus.hrdata = 32'(raw);
                OFS_ENABLE:  bus.hrdata = 32'(enable);
                OFS_PENDING: bus.hrdata = 32'(pending);
                OFS_MODE:    bus.hrdata = 32'(mode);
                OFS_ID:      bus.hrdata = 32'(id);
                default:     bus.hrdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.hready_out = 1'b1;
        bus.hresp      = 1'b0;
        case (state)
            IDLE: begin
                if (acc_bad) state_nxt = ERR1;
            end
            ERR1: begin
                bus.hready_out = 1'b0;
                bus.hresp      = 1'b1;
                state_nxt      = ERR2;
            end
            ERR2: begin
                bus.hresp = 1'b1;
                state_nxt = acc_bad ? ERR1 : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl; expected values are hand-computed per scenario.
module tb_irq_ctrl;

    localparam int NUM_SRC = 7;
`ifdef IRQC_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_SRC-1:0] irq_src;
    logic [NUM_SRC-1:0] irq;
    logic [31:0]        rdat;

    int n_cmp = 0;
    int n_err = 0;

    irq_ctrl_if #(.ADDR_W(16)) bus ();

    assign bus.hready = bus.hready_out;

    irq_ctrl #(.NUM_SRC(NUM_SRC), .ADDR_W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .irq_src (irq_src),
        .bus     (bus),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus.hsel   = 1'b0;
        bus.htrans = 2'b00;
        bus.hwrite = 1'b0;
        bus.haddr  = 16'h0;
    endtask

    task automatic addr_phase(input logic [15:0] a, input logic w);
        bus.hsel   = 1'b1;
        bus.htrans = 2'b10;
        bus.hwrite = w;
        bus.haddr  = a;
    endtask

    task automatic ahb_write(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        addr_phase(a, 1'b1);
        @(negedge clk);
        bus_idle();
        bus.hwdata = d;
        @(negedge clk);
    endtask

    task automatic ahb_read(input logic [15:0] a, output logic [31:0] d);
        @(negedge clk);
        addr_phase(a, 1'b0);
        @(negedge clk);
        bus_idle();
        d = bus.hrdata;
    endtask

    initial begin
        rst        = 1'b1;
        irq_src    = '0;
        bus.hwdata = 32'h0;
        bus_idle();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: reset state
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_hresp", 32'(bus.hresp), 32'h0);
        check("rst_hready_out", 32'(bus.hready_out), 32'h1);
        ahb_read(16'h00, rdat); check("rst_raw", rdat, 32'h0);
        ahb_read(16'h04, rdat); check("rst_enable", rdat, 32'h0);
        ahb_read(16'h08, rdat); check("rst_pending", rdat, 32'h0);
        ahb_read(16'h0C, rdat); check("rst_mode", rdat, 32'h0);
        ahb_read(16'h10, rdat); check("rst_id", rdat, 32'h1F);
        ahb_read(16'h14, rdat); check("rst_swset", rdat, 32'h0);

        // 2: edge pulse on source 0
        ahb_write(16'h0C, 32'h01);
        ahb_write(16'h04, 32'h01);
        irq_src[0] = 1'b1;
        @(negedge clk);
        irq_src[0] = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        check("edge_irq_latency", 32'(irq), 32'h0);
        @(negedge clk);
        check("edge_irq", 32'(irq), 32'h01);
        ahb_read(16'h08, rdat); check("edge_pending", rdat, 32'h01);
        ahb_read(16'h10, rdat); check("edge_id", rdat, 32'h20);
        ahb_write(16'h08, 32'h01);
        @(negedge clk);
        check("w1c_irq", 32'(irq), 32'h0);
        ahb_read(16'h08, rdat); check("w1c_pending", rdat, 32'h0);

        // 3: level mode on source 3
        ahb_write(16'h0C, 32'h00);
        ahb_write(16'h04, 32'h7F);
        irq_src[3] = 1'b1;
        repeat (LAT + 1) @(negedge clk);
        check("lvl_irq", 32'(irq), 32'h08);
        ahb_read(16'h00, rdat); check("lvl_raw", rdat, 32'h08);
        ahb_read(16'h10, rdat); check("lvl_id", rdat, 32'h23);
        ahb_write(16'h08, 32'h08);
        ahb_read(16'h08, rdat); check("lvl_w1c_ignored", rdat, 32'h08);
        ahb_write(16'h14, 32'h08);
        irq_src[3] = 1'b0;
        repeat (LAT + 1) @(negedge clk);
        ahb_read(16'h08, rdat); check("lvl_pending_drop", rdat, 32'h0);
        ahb_read(16'h10, rdat); check("lvl_id_none", rdat, 32'h1F);
        check("lvl_irq_drop", 32'(irq), 32'h0);

        // 4: W1C coinciding with a rising edge on source 2, masked off
        ahb_write(16'h04, 32'h03);
        ahb_write(16'h0C, 32'h04);
        if (LAT == 3) begin
            @(negedge clk);
            irq_src[2] = 1'b1;
        end
        @(negedge clk);
        addr_phase(16'h08, 1'b1);
        @(negedge clk);
        bus_idle();
        bus.hwdata = 32'h04;
        if (LAT == 1) irq_src[2] = 1'b1;
        @(negedge clk);
        ahb_read(16'h08, rdat); check("setwins_pending", rdat, 32'h04);
        check("setwins_irq_masked", 32'(irq), 32'h0);
        ahb_read(16'h10, rdat); check("setwins_id", rdat, 32'h1F);
        irq_src[2] = 1'b0;

        // 5: unmapped read then unmapped write, back to back
        @(negedge clk);
        addr_phase(16'h18, 1'b0);
        @(negedge clk);
        check("err_a_ready", 32'(bus.hready_out), 32'h0);
        check("err_a_resp", 32'(bus.hresp), 32'h1);
        check("err_a_rdata", bus.hrdata, 32'h0);
        addr_phase(16'h1C, 1'b1);
        @(negedge clk);
        check("err_b_ready", 32'(bus.hready_out), 32'h1);
        check("err_b_resp", 32'(bus.hresp), 32'h1);
        @(negedge clk);
        bus_idle();
        bus.hwdata = 32'hFFFF_FFFF;
        check("err_c_ready", 32'(bus.hready_out), 32'h0);
        check("err_c_resp", 32'(bus.hresp), 32'h1);
        @(negedge clk);
        check("err_d_ready", 32'(bus.hready_out), 32'h1);
        check("err_d_resp", 32'(bus.hresp), 32'h1);
        @(negedge clk);
        check("err_done_resp", 32'(bus.hresp), 32'h0);
        check("err_done_ready", 32'(bus.hready_out), 32'h1);
        ahb_read(16'h04, rdat); check("err_enable_kept", rdat, 32'h03);
        ahb_read(16'h0C, rdat); check("err_mode_kept", rdat, 32'h04);
        ahb_read(16'h08, rdat); check("err_pending_kept", rdat, 32'h04);

        // 6: reset during the data phase of an ENABLE write
        @(negedge clk);
        addr_phase(16'h04, 1'b1);
        @(negedge clk);
        bus_idle();
        bus.hwdata = 32'h7F;
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_irq", 32'(irq), 32'h0);
        check("rstmid_hresp", 32'(bus.hresp), 32'h0);
        check("rstmid_ready", 32'(bus.hready_out), 32'h1);
        ahb_read(16'h04, rdat); check("rstmid_enable", rdat, 32'h0);
        ahb_read(16'h08, rdat); check("rstmid_pending", rdat, 32'h0);

        // 7: SWSET only affects edge-mode bits
        ahb_write(16'h0C, 32'h04);
        ahb_write(16'h04, 32'h0C);
        ahb_write(16'h14, 32'h0C);
        ahb_read(16'h08, rdat); check("swset_pending", rdat, 32'h04);
        check("swset_irq", 32'(irq), 32'h04);
        ahb_read(16'h10, rdat); check("swset_id", rdat, 32'h22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
